// File: rtl/adc_scan_scheduler.sv
// rtl/adc_scan_scheduler.sv - round-robin scheduler sharing one ADC frame engine among three requesters.
// Optional ADC_AVG_EN: four conversions per grant, result is their truncated mean.
module adc_scan_scheduler #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req_valid,
    input  logic [8:0] req_ch,
    output logic [2:0] req_ready,
    output logic [2:0] rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       conv_start,
    output logic [2:0] conv_ch,
    input  logic       conv_done,
    input  logic [7:0] conv_data,
    output logic       busy
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t        state;
    state_t        state_nx;
    logic [1:0]    rr_ptr;
    logic [1:0]    winner;
    logic          any_req;
    logic [1:0]    owner;
    logic [CW-1:0] cnt;
    logic          timeout;
    logic          last_round;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

`ifdef ADC_AVG_EN
    logic [1:0] round;
    logic [9:0] acc;
    logic [9:0] acc_sum;
    assign acc_sum    = acc + 10'(conv_data);
    assign last_round = (round == 2'd3);
`else
    assign last_round = 1'b1;
`endif

    assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign busy    = (state != IDLE);

    // Descending offsets so the requester closest to rr_ptr is assigned last and wins.
    always_comb begin
        winner  = rr_ptr;
        any_req = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            if (req_valid[wrap3({1'b0, rr_ptr} + 3'(k))]) begin
                winner  = wrap3({1'b0, rr_ptr} + 3'(k));
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req_ready  = '0;
        rsp_valid  = '0;
        conv_start = 1'b0;
        case (state)
            IDLE: begin
                if (any_req && rst_n) begin
                    req_ready[winner] = 1'b1;
                    state_nx          = START;
                end
            end
            START: begin
                conv_start = 1'b1;
                state_nx   = WAIT;
            end
            WAIT: begin
                if (conv_done)    state_nx = last_round ? RESP : START;
                else if (timeout) state_nx = RESP;
            end
            RESP: begin
                rsp_valid[owner] = 1'b1;
                state_nx         = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            owner    <= '0;
            conv_ch  <= '0;
            cnt      <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
`ifdef ADC_AVG_EN
            round    <= '0;
            acc      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner   <= winner;
                        conv_ch <= req_ch[3*winner +: 3];
                        rr_ptr  <= wrap3({1'b0, winner} + 3'd1);
`ifdef ADC_AVG_EN
                        round   <= '0;
                        acc     <= '0;
`endif
                    end
                end
                START: cnt <= '0;
                WAIT: begin
                    // A completion in the last timeout cycle still counts as success.
                    if (conv_done) begin
`ifdef ADC_AVG_EN
                        if (last_round) begin
                            rsp_data <= acc_sum[9:2];
                            rsp_err  <= 1'b0;
                        end else begin
                            acc   <= acc_sum;
                            round <= round + 2'd1;
                        end
`else
                        rsp_data <= conv_data;
                        rsp_err  <= 1'b0;
`endif
                    end else if (timeout) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
